flip_flop_fifo_with_thresholds: RTL and testbench
=================================================

# flip_flop_fifo_with_thresholds

Parametrised flip-flop FIFO that succeeds the fixed-size counter-based FIFO used in the lab designs. It supports any depth, not only powers of two, and reports an explicit fill level. It adds programmable almost-full and almost-empty thresholds and accepts a push into a full FIFO when a pop happens in the same cycle. It sits between independent producer and consumer logic in one clock domain, for example key-driven push/pop logic feeding a seven-segment display.

## Interface

- `width`, 8, data word width in bits (≥1)
- `depth`, 5, number of entries (≥2; need not be a power of two)
- `almost_full_level`, `depth - 1`, `almost_full` asserts when `level >= almost_full_level` (1..depth)
- `almost_empty_level`, 1, `almost_empty` asserts when `level <= almost_empty_level` (0..depth-1)
- `w_level`, `$clog2(depth + 1)`, width of `level`; derived, do not override

- `clk`  input  1  the only clock; all state changes on its rising edge
- `rst`  input  1  synchronous, active-high reset
- `push`  input  1  write request
- `write_data`  input  width  data written when a push is accepted
- `pop`  input  1  read request
- `read_data`  output  width  head entry (show-ahead); valid only while `empty` = 0
- `empty`  output  1  `level == 0`
- `full`  output  1  `level == depth`
- `almost_empty`  output  1  `level <= almost_empty_level`
- `almost_full`  output  1  `level >= almost_full_level`
- `level`  output  w_level  number of stored entries
- `overflow`  output  1  sticky flag: a push was rejected
- `underflow`  output  1  sticky flag: a pop was rejected

## Operation

- Storage is a register array of `depth` words. It is not reset.
- Write pointer and read pointer each run from 0 to `depth-1`. On an accepted advance from `depth-1`, a pointer wraps to 0. Pointer width is `$clog2(depth)`.
- Pop is accepted when `pop & ~empty`. An accepted pop advances the read pointer.
- Push is accepted when `push & (~full | pop_accepted)`. An accepted push writes `write_data` at the write pointer and advances the write pointer.
- Level update:
  - +1 on push only
  - −1 on pop only
  - unchanged when both are accepted or neither is accepted
- Push and pop while full: both are accepted, and level stays at `depth`.
- Push and pop while empty: the pop is rejected (underflow), the push is accepted, and level becomes 1.
- A rejected push or pop does not change the pointers or the storage.
- `overflow` sets on `push & full & ~pop`. `underflow` sets on `pop & empty`. Both flags clear only on `rst`.
- `read_data` is `storage[rd_ptr]`, decoded combinationally.
- All status outputs decode combinationally from the registered `level`. No extra counters are used.

## Timing

- Reset values:
  - `level` = 0, both pointers = 0
  - `empty` = 1, `full` = 0
  - `almost_empty` = 1, `almost_full` = 0
  - `overflow` = 0, `underflow` = 0
- `read_data` is undefined until the first push.
- If `rst` is asserted mid-operation, all stored content is discarded at that edge, and `push`/`pop` in that cycle are ignored.
- Push-to-read latency is 1 cycle: a word pushed at edge N appears on `read_data` after edge N with `empty` = 0, if the FIFO was empty before.
- A pop at edge N exposes the next entry on `read_data` after edge N.
- Flags and `level` reflect the state after the most recent edge. They never depend combinationally on `push` or `pop`.
- No combinational path exists from `push`/`pop` to any output.

## Configuration

- Macro `FLIP_FLOP_FIFO_ERROR_FLAGS_EN`.
- Defined: `overflow` and `underflow` are implemented as sticky registers as described above.
- Not defined:
  - both ports remain in the interface and are tied to 0
  - the detection logic is removed
  - rejected pushes and pops are still ignored silently
  - all other behaviour is identical

## Test plan

- Reset, then 5 pushes of 0x2, 0x6, 0xd, 0xb, 0x7 (width 4, depth 5) → `level` steps 1..5. `almost_full` is set at level 4 and `full` at level 5. `read_data` stays 0x2 throughout.
- Full FIFO, push 0xe with pop in the same cycle → `level` stays 5. Over the next 5 cycles, pops return 0x6, 0xd, 0xb, 0x7, 0xe. `overflow` = 0.
- Full FIFO, push 0xc with no pop → contents unchanged, `overflow` = 1 and stays 1 through 10 more cycles. With the macro undefined, `overflow` = 0.
- Empty FIFO, push 0x9 with pop in the same cycle → `underflow` = 1, `level` = 1, `read_data` = 0x9.
- Depth 5 wrap test: 12 alternating push/pop pairs, data 0..11 → each pop returns the value pushed one cycle earlier. The pointers wrap from 4 to 0 twice.
- Load 3 entries, assert `rst` for 1 cycle with push=1 → `level` = 0, `empty` = 1, `almost_empty` = 1, all flags 0.

Source files
------------

// File: rtl/flip_flop_fifo_with_thresholds.sv
// flip_flop_fifo_with_thresholds
// Register-array FIFO for any depth (not only powers of two), with an explicit
// fill level, programmable almost-full/almost-empty thresholds, and a push
// into a full FIFO accepted when a pop happens in the same cycle.
// Optional feature macro: FLIP_FLOP_FIFO_ERROR_FLAGS_EN enables the sticky
// overflow/underflow registers. When it is undefined, both ports are tied to 0.
module flip_flop_fifo_with_thresholds #(
  parameter int width              = 8,
  parameter int depth              = 5,
  parameter int almost_full_level  = depth - 1,
  parameter int almost_empty_level = 1,
  parameter int w_level            = $clog2(depth + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [width-1:0]   write_data,
  input  logic               pop,
  output logic [width-1:0]   read_data,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic [w_level-1:0] level,
  output logic               overflow,
  output logic               underflow
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [PW-1:0]      PTR_LAST = PW'(depth - 1);
  localparam logic [w_level-1:0] LVL_FULL = w_level'(depth);
  localparam logic [w_level-1:0] LVL_AF   = w_level'(almost_full_level);
  localparam logic [w_level-1:0] LVL_AE   = w_level'(almost_empty_level);

  logic [width-1:0]   mem_q [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [w_level-1:0] level_q, level_d;
  logic               pop_acc, push_acc;

  // Status decodes only from registered level, never from push/pop.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_FULL);
  assign almost_empty = (level_q <= LVL_AE);
  assign almost_full  = (level_q >= LVL_AF);
  assign level        = level_q;
  assign read_data    = mem_q[rd_ptr_q];

  // A pop frees a slot, so a push into a full FIFO is fine in the same cycle.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  // Next-state for pointers (wrap at depth-1) and level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop_acc)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    if (push_acc && !pop_acc)      level_d = level_q + w_level'(1);
    else if (pop_acc && !push_acc) level_d = level_q - w_level'(1);
  end

  // Pointer and level registers; reset discards content and ignores push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage: one write-enabled register per entry, deliberately not reset.
  for (genvar g = 0; g < depth; g++) begin : g_entry
    // Capture write_data when this entry is the accepted push target.
    always_ff @(posedge clk) begin
      if (!rst && push_acc && (wr_ptr_q == PW'(g))) mem_q[g] <= write_data;
    end
  end

`ifdef FLIP_FLOP_FIFO_ERROR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push & full & ~pop) overflow_q  <= 1'b1;
      if (pop & empty)        underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_flip_flop_fifo_with_thresholds.sv
// Directed testbench for flip_flop_fifo_with_thresholds (width 4, depth 5).
module tb_flip_flop_fifo_with_thresholds;

  localparam int W = 4;
  localparam int D = 5;
  localparam int WL = $clog2(D + 1);
`ifdef FLIP_FLOP_FIFO_ERROR_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, push, pop;
  logic [W-1:0]  write_data;
  logic [W-1:0]  read_data;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [WL-1:0] level;

  int checks = 0;
  int failures = 0;

  flip_flop_fifo_with_thresholds #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst), .push(push), .write_data(write_data), .pop(pop),
    .read_data(read_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; write_data = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin failures++;
      $display("FAIL reset_status got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++;
      $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_fill();
    logic [W-1:0] vals [5];
    vals = '{4'h2, 4'h6, 4'hd, 4'hb, 4'h7};
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; write_data = vals[i];
      tick();
      idle();
      checks++; if (level !== WL'(i + 1)) begin failures++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level, i + 1); end
      checks++; if (read_data !== 4'h2) begin failures++; $display("FAIL fill_head i=%0d got=%h exp=2", i, read_data); end
      checks++; if ({empty, full, almost_empty, almost_full} !== {1'b0, i == 4, i == 0, i >= 3}) begin failures++;
        $display("FAIL fill_status i=%0d got=%b exp=%b", i, {empty, full, almost_empty, almost_full},
                 {1'b0, i == 4, i == 0, i >= 3}); end
    end
  endtask

  task automatic test_push_pop_full();
    logic [W-1:0] exp [5];
    exp = '{4'h6, 4'hd, 4'hb, 4'h7, 4'he};
    push = 1'b1; pop = 1'b1; write_data = 4'he;
    tick();
    idle();
    checks++; if (level !== 3'd5 || full !== 1'b1) begin failures++;
      $display("FAIL ppfull_level got=%0d full=%b exp=5 full=1", level, full); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (read_data !== exp[i]) begin failures++; $display("FAIL ppfull_pop i=%0d got=%h exp=%h", i, read_data, exp[i]); end
      pop = 1'b1;
      tick();
      idle();
      checks++; if (almost_empty !== (i >= 3)) begin failures++;
        $display("FAIL ppfull_ae i=%0d got=%b exp=%b", i, almost_empty, i >= 3); end
    end
    checks++; if (empty !== 1'b1 || level !== 3'd0) begin failures++; $display("FAIL ppfull_empty got=%b/%0d exp=1/0", empty, level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ppfull_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      push = 1'b1; write_data = W'(i);
      tick();
    end
    push = 1'b1; write_data = 4'hc;
    tick();
    idle();
    checks++; if (level !== 3'd5 || read_data !== 4'h1) begin failures++;
      $display("FAIL ovf_state got lvl=%0d head=%h exp lvl=5 head=1", level, read_data); end
    checks++; if (overflow !== FLAGS) begin failures++; $display("FAIL ovf_set got=%b exp=%b", overflow, FLAGS); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (overflow !== FLAGS) begin failures++; $display("FAIL ovf_sticky got=%b exp=%b", overflow, FLAGS); end
    for (int i = 1; i <= 5; i++) begin
      checks++; if (read_data !== W'(i)) begin failures++; $display("FAIL ovf_content i=%0d got=%h exp=%h", i, read_data, W'(i)); end
      pop = 1'b1;
      tick();
      idle();
    end
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin failures++;
      $display("FAIL ovf_drain got empty=%b unf=%b exp 1/0", empty, underflow); end
  endtask

  task automatic test_push_pop_empty();
    push = 1'b1; pop = 1'b1; write_data = 4'h9;
    tick();
    idle();
    checks++; if (level !== 3'd1 || read_data !== 4'h9) begin failures++;
      $display("FAIL ppempty got lvl=%0d data=%h exp lvl=1 data=9", level, read_data); end
    checks++; if (underflow !== FLAGS) begin failures++; $display("FAIL ppempty_unf got=%b exp=%b", underflow, FLAGS); end
    pop = 1'b1;
    tick();
    idle();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ppempty_drain got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      push = 1'b1; write_data = W'(i);
      tick();
      idle();
      checks++; if (read_data !== W'(i) || level !== 3'd1) begin failures++;
        $display("FAIL wrap_push i=%0d got data=%h lvl=%0d exp data=%h lvl=1", i, read_data, level, W'(i)); end
      pop = 1'b1;
      tick();
      idle();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_pop i=%0d got empty=%b exp=1", i, empty); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; write_data = 4'ha + W'(i);
      tick();
    end
    rst = 1'b1; push = 1'b1; write_data = 4'hf;
    tick();
    idle();
    checks++; if (level !== 3'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin failures++;
      $display("FAIL rstmid_state got lvl=%0d e=%b ae=%b exp 0/1/1", level, empty, almost_empty); end
    checks++; if ({full, almost_full, overflow, underflow} !== 4'b0000) begin failures++;
      $display("FAIL rstmid_flags got=%b exp=0000", {full, almost_full, overflow, underflow}); end
    push = 1'b1; write_data = 4'h5;
    tick();
    idle();
    checks++; if (read_data !== 4'h5 || level !== 3'd1) begin failures++;
      $display("FAIL rstmid_after got data=%h lvl=%0d exp 5/1", read_data, level); end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; write_data = '0;
    #1;
    test_reset();
    test_fill();
    test_push_pop_full();
    test_overflow();
    test_push_pop_empty();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
